// File: rtl/csr_arbiter_pkg.sv
// Shared definitions for the CSR arbiter: operation encoding, address width,
// the read-only address field, and the arbiter's internal enums.
package csr_arbiter_pkg;

   localparam int         CSR_ADDR_W   = 12;
   localparam logic [1:0] CSR_RO_FIELD = 2'b11;

   typedef enum logic [1:0] {
      CSR_RW   = 2'd0,
      CSR_RS   = 2'd1,
      CSR_RC   = 2'd2,
      CSR_RSVD = 2'd3
   } csr_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_TRAP = 1'b1
   } owner_t;

endpackage

// File: rtl/csr_arbiter_alu.sv
// Combinational read-modify-write datapath: new CSR value from op, old value
// and operand. The reserved op leaves the value unchanged.
module csr_alu
   import csr_arbiter_pkg::*;
(
   input  csr_op_t     op,
   input  logic [31:0] old,
   input  logic [31:0] operand,
   output logic [31:0] result
);

   always_comb begin
      result = old;
      case (op)
         CSR_RW:  result = operand;
         CSR_RS:  result = old | operand;
         CSR_RC:  result = old & ~operand;
         default: result = old;
      endcase
   end

endmodule

// File: rtl/csr_arbiter.sv
// Arbitrates a core CSR port and a trap-unit write port onto a single-port
// CSR file, one read-modify-write transaction at a time.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | csr_sel = 0, grant and accept one requester
// ST_READ  | drive latched address, capture old CSR value
// ST_WRITE | drive new value, csr_wen if permitted; trap ends here
// ST_RESP  | hold core response until core_resp_ready
module csr_arbiter
   import csr_arbiter_pkg::*;
#(
   parameter bit TRAP_PRIORITY = 1'b1,
   parameter bit RO_CHECK      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  core_req_valid,
   output logic                  core_req_ready,
   input  logic [1:0]            core_req_op,
   input  logic [CSR_ADDR_W-1:0] core_req_addr,
   input  logic [31:0]           core_req_wdata,
   input  logic                  core_req_wr,
   output logic                  core_resp_valid,
   input  logic                  core_resp_ready,
   output logic [31:0]           core_resp_rdata,
   output logic                  core_resp_illegal,
   input  logic                  trap_req_valid,
   output logic                  trap_req_ready,
   input  logic [CSR_ADDR_W-1:0] trap_req_addr,
   input  logic [31:0]           trap_req_wdata,
   output logic                  trap_done,
   output logic [CSR_ADDR_W-1:0] csr_sel,
   output logic [31:0]           csr_wdata,
   output logic                  csr_wen,
   input  logic [31:0]           csr_rdata
);

   arb_state_t            state_q, state_d;
   owner_t                owner_q;
   csr_op_t               op_q;
   logic [CSR_ADDR_W-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  wr_q;
   logic [31:0]           old_q;

   logic        grant_core, grant_trap;
   logic        illegal, write_ok;
   logic [31:0] new_val;

   assign grant_trap = trap_req_valid && (!core_req_valid || TRAP_PRIORITY);
   assign grant_core = core_req_valid && (!trap_req_valid || !TRAP_PRIORITY);

   // The read still happens for illegal accesses; only the write is blocked.
   assign illegal  = (op_q == CSR_RSVD) ||
                     (RO_CHECK && wr_q && (addr_q[CSR_ADDR_W-1 -: 2] == CSR_RO_FIELD));
   assign write_ok = wr_q && (op_q != CSR_RSVD) && !illegal;

   csr_alu u_alu (
      .op      (op_q),
      .old     (old_q),
      .operand (wdata_q),
      .result  (new_val)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_CORE;
         op_q    <= CSR_RW;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         old_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && grant_trap) begin
            owner_q <= OWN_TRAP;
            op_q    <= CSR_RW;
            addr_q  <= trap_req_addr;
            wdata_q <= trap_req_wdata;
            wr_q    <= 1'b1;
         end else if (state_q == ST_IDLE && grant_core) begin
            owner_q <= OWN_CORE;
            op_q    <= csr_op_t'(core_req_op);
            addr_q  <= core_req_addr;
            wdata_q <= core_req_wdata;
            wr_q    <= core_req_wr;
         end
         if (state_q == ST_READ) old_q <= csr_rdata;
      end
   end

   always_comb begin
      state_d           = state_q;
      core_req_ready    = 1'b0;
      trap_req_ready    = 1'b0;
      core_resp_valid   = 1'b0;
      core_resp_rdata   = '0;
      core_resp_illegal = 1'b0;
      trap_done         = 1'b0;
      csr_sel           = '0;
      csr_wdata         = '0;
      csr_wen           = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Ready is masked while rst is low so outputs stay quiet in reset.
            if (rst) begin
               core_req_ready = grant_core;
               trap_req_ready = grant_trap;
               if (grant_core || grant_trap) state_d = ST_READ;
            end
         end
         ST_READ: begin
            csr_sel = addr_q;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            csr_sel   = addr_q;
            csr_wdata = new_val;
            csr_wen   = write_ok;
            if (owner_q == OWN_TRAP) begin
               trap_done = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            core_resp_valid   = 1'b1;
            core_resp_rdata   = old_q;
            core_resp_illegal = illegal;
            if (core_resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter against a behavioural single-port CSR file
// (combinational read, write on the falling edge).
module tb_csr_arbiter;

   localparam logic [1:0] OP_RW = 2'd0;
   localparam logic [1:0] OP_RS = 2'd1;
   localparam logic [1:0] OP_RC = 2'd2;
   localparam logic [1:0] OP_RV = 2'd3;

   logic        clk;
   logic        rst;
   logic        core_req_valid, core_req_ready;
   logic [1:0]  core_req_op;
   logic [11:0] core_req_addr;
   logic [31:0] core_req_wdata;
   logic        core_req_wr;
   logic        core_resp_valid, core_resp_ready;
   logic [31:0] core_resp_rdata;
   logic        core_resp_illegal;
   logic        trap_req_valid, trap_req_ready;
   logic [11:0] trap_req_addr;
   logic [31:0] trap_req_wdata;
   logic        trap_done;
   logic [11:0] csr_sel;
   logic [31:0] csr_wdata;
   logic        csr_wen;
   logic [31:0] csr_rdata;

   logic [31:0] csr_mem [0:4095];
   logic        pre_en;
   logic [11:0] pre_addr;
   logic [31:0] pre_data;
   int          wen_cnt;
   int          n_vec;
   int          n_err;

   csr_arbiter #(.TRAP_PRIORITY(1'b1), .RO_CHECK(1'b1)) dut (
      .clk               (clk),
      .rst               (rst),
      .core_req_valid    (core_req_valid),
      .core_req_ready    (core_req_ready),
      .core_req_op       (core_req_op),
      .core_req_addr     (core_req_addr),
      .core_req_wdata    (core_req_wdata),
      .core_req_wr       (core_req_wr),
      .core_resp_valid   (core_resp_valid),
      .core_resp_ready   (core_resp_ready),
      .core_resp_rdata   (core_resp_rdata),
      .core_resp_illegal (core_resp_illegal),
      .trap_req_valid    (trap_req_valid),
      .trap_req_ready    (trap_req_ready),
      .trap_req_addr     (trap_req_addr),
      .trap_req_wdata    (trap_req_wdata),
      .trap_done         (trap_done),
      .csr_sel           (csr_sel),
      .csr_wdata         (csr_wdata),
      .csr_wen           (csr_wen),
      .csr_rdata         (csr_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign csr_rdata = csr_mem[csr_sel];

   initial wen_cnt = 0;
   always @(negedge clk) begin
      if (pre_en) csr_mem[pre_addr] = pre_data;
      if (csr_wen) begin
         csr_mem[csr_sel] = csr_wdata;
         wen_cnt = wen_cnt + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100us");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      pre_addr = a;
      pre_data = d;
      pre_en   = 1'b1;
      @(negedge clk);
      #1 pre_en = 1'b0;
      tick();
   endtask

   // Full core transaction with resp_ready held high; starts and ends in IDLE.
   task automatic core_txn(input string tag, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic wr,
                           input logic [31:0] exp_rdata, input logic exp_ill,
                           input logic [31:0] exp_new, input int exp_wen);
      int w0;
      w0 = wen_cnt;
      core_req_valid  = 1'b1;
      core_req_op     = op;
      core_req_addr   = addr;
      core_req_wdata  = wdata;
      core_req_wr     = wr;
      core_resp_ready = 1'b1;
      #1;
      check({tag, " idle ready"}, core_req_ready, 1);
      check({tag, " idle sel"}, csr_sel, 0);
      tick();
      core_req_valid = 1'b0;
      #1;
      check({tag, " read sel"}, csr_sel, addr);
      check({tag, " read wen"}, csr_wen, 0);
      tick();
      #1;
      check({tag, " write sel"}, csr_sel, addr);
      check({tag, " write wen"}, csr_wen, exp_wen);
      if (exp_wen != 0) check({tag, " write data"}, csr_wdata, exp_new);
      tick();
      #1;
      check({tag, " resp valid"}, core_resp_valid, 1);
      check({tag, " resp rdata"}, core_resp_rdata, exp_rdata);
      check({tag, " resp illegal"}, core_resp_illegal, exp_ill);
      tick();
      check({tag, " back idle"}, core_resp_valid, 0);
      check({tag, " wen count"}, wen_cnt - w0, exp_wen);
   endtask

   initial begin
      int w0;
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      pre_en = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      core_req_valid = 1'b0;
      core_req_op = OP_RW;
      core_req_addr = '0;
      core_req_wdata = '0;
      core_req_wr = 1'b0;
      core_resp_ready = 1'b1;
      trap_req_valid = 1'b0;
      trap_req_addr = '0;
      trap_req_wdata = '0;

      // Outputs quiet during reset even with both requesters valid
      repeat (2) @(posedge clk);
      #2;
      core_req_valid = 1'b1;
      trap_req_valid = 1'b1;
      #1;
      check("rst core_ready", core_req_ready, 0);
      check("rst trap_ready", trap_req_ready, 0);
      check("rst resp_valid", core_resp_valid, 0);
      check("rst resp_rdata", core_resp_rdata, 0);
      check("rst illegal", core_resp_illegal, 0);
      check("rst trap_done", trap_done, 0);
      check("rst csr_sel", csr_sel, 0);
      check("rst csr_wdata", csr_wdata, 0);
      check("rst csr_wen", csr_wen, 0);
      core_req_valid = 1'b0;
      trap_req_valid = 1'b0;

      preload(12'h300, 32'h8);
      preload(12'hC00, 32'h55);
      preload(12'h341, 32'hDEAD);
      preload(12'h340, 32'h0F0F);
      rst = 1'b1;
      tick();

      core_txn("rs", OP_RS, 12'h300, 32'h3, 1'b1, 32'h8, 1'b0, 32'hB, 1);
      check("rs csr value", csr_mem[12'h300], 32'hB);
      core_txn("rc nowr", OP_RC, 12'h300, 32'h1, 1'b0, 32'hB, 1'b0, 32'h0, 0);
      check("rc csr value", csr_mem[12'h300], 32'hB);
      core_txn("ro", OP_RW, 12'hC00, 32'h1, 1'b1, 32'h55, 1'b1, 32'h0, 0);
      check("ro csr value", csr_mem[12'hC00], 32'h55);
      core_txn("rsvd", OP_RV, 12'h300, 32'hFF, 1'b1, 32'hB, 1'b1, 32'h0, 0);
      check("rsvd csr value", csr_mem[12'h300], 32'hB);
      core_txn("rw", OP_RW, 12'h340, 32'h1234, 1'b1, 32'h0F0F, 1'b0, 32'h1234, 1);
      core_txn("rc b2b", OP_RC, 12'h340, 32'h4, 1'b1, 32'h1234, 1'b0, 32'h1230, 1);
      check("rc b2b csr value", csr_mem[12'h340], 32'h1230);

      // Simultaneous trap and core requests: trap wins
      w0 = wen_cnt;
      core_req_valid = 1'b1;
      core_req_op    = OP_RS;
      core_req_addr  = 12'h341;
      core_req_wdata = 32'h0;
      core_req_wr    = 1'b0;
      trap_req_valid = 1'b1;
      trap_req_addr  = 12'h341;
      trap_req_wdata = 32'h1000;
      #1;
      check("prio trap_ready", trap_req_ready, 1);
      check("prio core_ready", core_req_ready, 0);
      tick();
      trap_req_valid = 1'b0;
      #1;
      check("trap read core_ready", core_req_ready, 0);
      check("trap read done", trap_done, 0);
      check("trap read sel", csr_sel, 12'h341);
      tick();
      #1;
      check("trap write done", trap_done, 1);
      check("trap write wen", csr_wen, 1);
      check("trap write data", csr_wdata, 32'h1000);
      tick();
      check("trap after done", trap_done, 0);
      check("trap resp_valid", core_resp_valid, 0);
      check("trap csr value", csr_mem[12'h341], 32'h1000);
      check("trap wen count", wen_cnt - w0, 1);
      core_txn("after trap", OP_RS, 12'h341, 32'h0, 1'b0, 32'h1000, 1'b0, 32'h0, 0);

      // Response back-pressure: held stable, no new grant
      core_resp_ready = 1'b0;
      core_req_valid  = 1'b1;
      core_req_op     = OP_RW;
      core_req_addr   = 12'h340;
      core_req_wdata  = 32'hAAAA;
      core_req_wr     = 1'b1;
      tick();
      core_req_valid = 1'b0;
      tick();
      tick();
      trap_req_valid = 1'b1;
      trap_req_addr  = 12'h342;
      trap_req_wdata = 32'h77;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("hold valid", core_resp_valid, 1);
         check("hold rdata", core_resp_rdata, 32'h1230);
         check("hold illegal", core_resp_illegal, 0);
         check("hold trap_ready", trap_req_ready, 0);
         tick();
      end
      check("hold last valid", core_resp_valid, 1);
      core_resp_ready = 1'b1;
      tick();
      #1;
      check("release resp_valid", core_resp_valid, 0);
      check("release trap_ready", trap_req_ready, 1);
      tick();
      trap_req_valid = 1'b0;
      tick();
      #1;
      check("bp trap done", trap_done, 1);
      tick();
      check("bp csr 340", csr_mem[12'h340], 32'hAAAA);
      check("bp csr 342", csr_mem[12'h342], 32'h77);

      // Reset during READ drops the write
      w0 = wen_cnt;
      core_req_valid = 1'b1;
      core_req_op    = OP_RW;
      core_req_addr  = 12'h300;
      core_req_wdata = 32'hFFFF;
      core_req_wr    = 1'b1;
      #1;
      check("mid-rst accept", core_req_ready, 1);
      tick();
      core_req_valid = 1'b0;
      #1;
      check("mid-rst read sel", csr_sel, 12'h300);
      rst = 1'b0;
      #1;
      check("mid-rst sel", csr_sel, 0);
      check("mid-rst wen", csr_wen, 0);
      tick();
      tick();
      rst = 1'b1;
      check("mid-rst wen count", wen_cnt - w0, 0);
      check("mid-rst csr value", csr_mem[12'h300], 32'hB);
      core_txn("post rst", OP_RC, 12'h300, 32'h0, 1'b0, 32'hB, 1'b0, 32'h0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/csr_arbiter.md
CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 SHALL have parameter TRAP_PRIORITY, default 1: 1 means trap wins simultaneous requests, 0 means core wins.
REQ-002 SHALL have parameter RO_CHECK, default 1: 1 means writes to sel[11:10]==2'b11 are flagged illegal and suppressed.
REQ-003 SHALL have port clk  input  1  the only clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port core_req_valid  input  1  core CSR request present.
REQ-006 SHALL have port core_req_ready  output  1  core request accepted this cycle.
REQ-007 SHALL have port core_req_op  input  2  csr_op_t: RW=0, RS=1, RC=2, reserved=3.
REQ-008 SHALL have port core_req_addr  input  12  CSR address.
REQ-009 SHALL have port core_req_wdata  input  32  operand (rs1 value or zimm).
REQ-010 SHALL have port core_req_wr  input  1  write intent; 0 for RS/RC with rs1=x0 or zimm=0.
REQ-011 SHALL have port core_resp_valid  output  1  core result available.
REQ-012 SHALL have port core_resp_ready  input  1  core consumes result.
REQ-013 SHALL have port core_resp_rdata  output  32  old CSR value.
REQ-014 SHALL have port core_resp_illegal  output  1  access rejected.
REQ-015 SHALL have port trap_req_valid  input  1  trap-unit write request (always RW, always writes).
REQ-016 SHALL have port trap_req_ready  output  1  trap request accepted.
REQ-017 SHALL have port trap_req_addr  input  12  CSR address.
REQ-018 SHALL have port trap_req_wdata  input  32  value to write.
REQ-019 SHALL have port trap_done  output  1  one-cycle pulse when trap write completes.
REQ-020 SHALL have ports csr_sel output 12, csr_wdata output 32, csr_wen output 1, csr_rdata input 32 driving the single-port CSR file (combinational read, write on the falling edge).

Function
REQ-021 SHALL implement FSM IDLE -> READ -> WRITE -> RESP -> IDLE; trap transactions go WRITE -> IDLE and skip RESP.
REQ-022 SHALL assert a req_ready only in IDLE, and only for the granted requester; a transaction is accepted on valid&&ready.
REQ-023 SHALL grant by TRAP_PRIORITY when both are valid in IDLE; the grant is locked until the transaction returns to IDLE.
REQ-024 SHALL latch op, addr, wdata, wr and the owner at acceptance; request inputs are ignored after that.
REQ-025 SHALL drive csr_sel = latched addr in READ and WRITE, capture csr_rdata in READ, and hold csr_sel = 0 in IDLE.
REQ-026 SHALL compute the new value in WRITE as: RW = wdata; RS = old|wdata; RC = old&~wdata.
REQ-027 SHALL assert csr_wen for exactly one cycle (WRITE) only if wr=1, op is not reserved, and the access is not illegal.
REQ-028 SHALL flag illegal when op==3, or when RO_CHECK=1, wr=1 and addr[11:10]==2'b11; illegal flag SHALL NOT suppress the read.
REQ-029 SHALL hold core_resp_valid, rdata and illegal stable in RESP until core_resp_ready; return to IDLE on the handshake cycle.
REQ-030 SHALL pulse trap_done in the WRITE cycle of a trap transaction.
REQ-031 SHALL give core latency of 3 cycles from acceptance to first core_resp_valid; with resp_ready held high, throughput is one transaction per 4 cycles.
REQ-032 SHALL return the pre-write value when consecutive transactions target the same address, and the second SHALL observe the first's write.

Reset
REQ-033 SHALL, on rst low at any time including mid-transaction, enter IDLE and drop any in-flight write.
REQ-034 SHALL, during reset, hold all outputs at 0: ready, resp_valid, rdata, illegal, trap_done, csr_sel, csr_wdata and csr_wen.
REQ-035 SHALL reach IDLE on the first rising clk edge after rst deasserts and may accept a request in that cycle.

Structure
REQ-036 SHALL take csr_op_t, the CSR address width (12) and the read-only field constant 2'b11 from the shared core package.
REQ-037 SHALL contain one sub-module, csr_alu, which is combinational (op, old, operand -> new value).

Verification
REQ-038 SHALL test core RS with addr 0x300, CSR=0x8, wdata=0x3, wr=1 -> resp rdata=0x8, CSR becomes 0xB, csr_wen high for exactly 1 cycle.
REQ-039 SHALL test core RC with wr=0 on 0x300 -> rdata returned, csr_wen never asserted.
REQ-040 SHALL test core RW to 0xC00 -> illegal=1, rdata=current value, no write.
REQ-041 SHALL test trap and core valid in the same cycle, TRAP_PRIORITY=1 -> trap writes 0x341=0x1000 and trap_done pulses; core then reads 0x341 and gets 0x1000.
REQ-042 SHALL test core_resp_ready held low for 5 cycles -> resp held stable and no new grant; trap_req_ready stays 0.
REQ-043 SHALL test rst asserted during READ -> FSM returns to IDLE, no csr_wen, and the CSR value is unchanged.
